// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding and
// the hard-wired zero register index.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of hazard-detect inputs and pipeline-register controls between the
// pipeline datapath (master) and the hazard sequencer (slave).
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       ifid_rs1;
    logic [4:0]       ifid_rs2;
    logic             idex_memread;
    logic [4:0]       idex_rd;
    logic             mem_branch_taken;
    logic             dmem_busy;
    logic             cnt_clr;
    logic             err_clr;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_flush;
    logic             exmem_write;
    logic             exmem_flush;
    logic             memwb_write;
    logic             state;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ifid_rs1, ifid_rs2, idex_memread, idex_rd, mem_branch_taken,
               dmem_busy, cnt_clr, err_clr,
        input  pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, exmem_flush, memwb_write, state, timeout_err,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  ifid_rs1, ifid_rs2, idex_memread, idex_rd, mem_branch_taken,
               dmem_busy, cnt_clr, err_clr,
        output pc_write, ifid_write, ifid_flush, idex_write, idex_flush,
               exmem_write, exmem_flush, memwb_write, state, timeout_err,
               stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority over
// increment; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory freeze, taken-branch
// flush (including a branch parked during a freeze), load-use bubble.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned TO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
);

    state_t          state_q;
    logic            br_pend_q;
    logic [TO_W-1:0] busy_run_q;
    logic [TO_W-1:0] busy_run_d;
    logic            timeout_err_q;

    logic lu;
    logic br;
    logic to_hit;

    logic pc_write, ifid_write, ifid_flush, idex_write;
    logic idex_flush, exmem_write, exmem_flush, memwb_write;

    assign lu = hz.idex_memread && (hz.idex_rd != X0) &&
                ((hz.idex_rd == hz.ifid_rs1) || (hz.idex_rd == hz.ifid_rs2));
    assign br = hz.mem_branch_taken || br_pend_q;

    // Controls are gated by the raw reset so the pipeline is frozen while it is held.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_write  = 1'b0;
        idex_flush  = 1'b0;
        exmem_write = 1'b0;
        exmem_flush = 1'b0;
        memwb_write = 1'b0;
        if (reset && !hz.dmem_busy) begin
            idex_write  = 1'b1;
            exmem_write = 1'b1;
            memwb_write = 1'b1;
            if (br) begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (lu) begin
                idex_flush  = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
            end
        end
    end

    always_comb begin
        busy_run_d = '0;
        if (hz.dmem_busy) begin
            busy_run_d = (busy_run_q == TO_W'(TIMEOUT)) ? busy_run_q
                                                         : busy_run_q + TO_W'(1);
        end
    end

    assign to_hit = hz.dmem_busy && (busy_run_q == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            br_pend_q     <= 1'b0;
            busy_run_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            busy_run_q <= busy_run_d;
            if (hz.dmem_busy) begin
                state_q   <= MEM_WAIT;
                br_pend_q <= br_pend_q || hz.mem_branch_taken;
            end else begin
                state_q   <= RUN;
                br_pend_q <= 1'b0;
            end
            if (to_hit) begin
                timeout_err_q <= 1'b1;
            end else if (hz.err_clr) begin
                timeout_err_q <= 1'b0;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (!pc_write),
        .clr   (hz.cnt_clr),
        .q     (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (ifid_flush),
        .clr   (hz.cnt_clr),
        .q     (hz.flush_cnt)
    );

    assign hz.pc_write    = pc_write;
    assign hz.ifid_write  = ifid_write;
    assign hz.ifid_flush  = ifid_flush;
    assign hz.idex_write  = idex_write;
    assign hz.idex_flush  = idex_flush;
    assign hz.exmem_write = exmem_write;
    assign hz.exmem_flush = exmem_flush;
    assign hz.memwb_write = memwb_write;
    assign hz.state       = state_q;
    assign hz.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a wide-counter and a 2-bit-counter instance share
// one stimulus stream and are checked against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int unsigned TO = 4;

    logic clk;
    logic rst_n;

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl_if #(.CNT_W(16)) ia ();
    pipe_hazard_ctrl_if #(.CNT_W(2))  ib ();

    pipe_hazard_ctrl #(.CNT_W(16), .TIMEOUT(TO), .TO_W(8)) dut_a (
        .clk   (clk),
        .reset (rst_n),
        .hz    (ia)
    );

    pipe_hazard_ctrl #(.CNT_W(2), .TIMEOUT(TO), .TO_W(8)) dut_b (
        .clk   (clk),
        .reset (rst_n),
        .hz    (ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, exmem_flush, memwb_write}
    logic [7:0] ctrl_a, ctrl_b;
    assign ctrl_a = {ia.pc_write, ia.ifid_write, ia.ifid_flush, ia.idex_write,
                     ia.idex_flush, ia.exmem_write, ia.exmem_flush, ia.memwb_write};
    assign ctrl_b = {ib.pc_write, ib.ifid_write, ib.ifid_flush, ib.idex_write,
                     ib.idex_flush, ib.exmem_write, ib.exmem_flush, ib.memwb_write};

    // Reference model state
    bit m_wait, m_pend, m_err;
    int m_run, m_stall, m_flush;

    task automatic model_reset();
        m_wait = 0; m_pend = 0; m_err = 0;
        m_run = 0; m_stall = 0; m_flush = 0;
    endtask

    function automatic int sat(input int cnt, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (cnt > mx) ? mx : cnt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".state_a"}, 32'(ia.state), 32'(m_wait));
        chk({tag, ".state_b"}, 32'(ib.state), 32'(m_wait));
        chk({tag, ".err_a"},   32'(ia.timeout_err), 32'(m_err));
        chk({tag, ".err_b"},   32'(ib.timeout_err), 32'(m_err));
        chk({tag, ".stall_a"}, 32'(ia.stall_cnt), 32'(sat(m_stall, 16)));
        chk({tag, ".stall_b"}, 32'(ib.stall_cnt), 32'(sat(m_stall, 2)));
        chk({tag, ".flush_a"}, 32'(ia.flush_cnt), 32'(sat(m_flush, 16)));
        chk({tag, ".flush_b"}, 32'(ib.flush_cnt), 32'(sat(m_flush, 2)));
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic mr,
                         input logic [4:0] rd, input logic mbt, input logic busy,
                         input logic cclr, input logic eclr);
        ia.ifid_rs1 = rs1; ia.ifid_rs2 = rs2; ia.idex_memread = mr; ia.idex_rd = rd;
        ia.mem_branch_taken = mbt; ia.dmem_busy = busy; ia.cnt_clr = cclr; ia.err_clr = eclr;
        ib.ifid_rs1 = rs1; ib.ifid_rs2 = rs2; ib.idex_memread = mr; ib.idex_rd = rd;
        ib.mem_branch_taken = mbt; ib.dmem_busy = busy; ib.cnt_clr = cclr; ib.err_clr = eclr;
    endtask

    // One pipeline cycle: drive, check same-cycle controls, advance model, check registers.
    task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic mr, input logic [4:0] rd, input logic mbt,
                        input logic busy, input logic cclr, input logic eclr);
        bit luv, brv, set;
        logic [7:0] exp;
        int run_n;
        drive(rs1, rs2, mr, rd, mbt, busy, cclr, eclr);
        luv = mr && (rd != 0) && (rd == rs1 || rd == rs2);
        brv = mbt || m_pend;
        if (busy)     exp = 8'b0000_0000;
        else if (brv) exp = 8'b1111_1111;
        else if (luv) exp = 8'b0001_1101;
        else          exp = 8'b1101_0101;
        #2;
        chk({tag, ".ctrl_a"}, 32'(ctrl_a), 32'(exp));
        chk({tag, ".ctrl_b"}, 32'(ctrl_b), 32'(exp));

        if (busy) begin
            run_n  = (m_run + 1 > int'(TO)) ? int'(TO) : m_run + 1;
            set    = (m_run < int'(TO)) && (run_n == int'(TO));
            m_wait = 1;
            m_pend = m_pend || mbt;
        end else begin
            run_n  = 0;
            set    = 0;
            m_wait = 0;
            m_pend = 0;
        end
        m_run = run_n;
        if (set)       m_err = 1;
        else if (eclr) m_err = 0;
        m_stall = cclr ? 0 : m_stall + (exp[7] ? 0 : 1);
        m_flush = cclr ? 0 : m_flush + (exp[5] ? 1 : 0);

        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    initial begin
        logic [4:0] r1, r2, rd;
        logic mr, mbt, busy, cclr, eclr;

        rst_n = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ctrl_a", 32'(ctrl_a), 32'd0);
        chk("reset.ctrl_b", 32'(ctrl_b), 32'd0);
        check_regs("reset");
        rst_n = 1'b1;

        // Load-use then the bubble-follow cycle
        step("lu",      5'd1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        step("lu_next", 5'd1, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        // Load into x0 never stalls
        step("rd_x0",   5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Branch beats load-use
        step("br_lu",   5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        // Branch parked during a 3-cycle freeze
        step("frz1",    5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("frz2",    5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("frz3",    5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("frz_out", 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("frz_aft", 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Watchdog: 5 busy cycles, error sticks, err_clr releases it
        for (int unsigned i = 0; i < 5; i++)
            step("wd_busy", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("wd_idle", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("wd_clr",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Set beats err_clr on the same edge
        for (int unsigned i = 0; i < 3; i++)
            step("wd2_busy", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        step("wd2_set",  5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        step("wd2_idle", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        // Clear wins over a stall, then saturate the 2-bit counter
        step("clr_lu",  5'd7, 5'd9, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int unsigned i = 0; i < 5; i++) begin
            step("sat_lu",  5'd7, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
            step("sat_nop", 5'd7, 5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Randomized traffic
        for (int unsigned i = 0; i < 400; i++) begin
            r1   = 5'($urandom_range(0, 3));
            r2   = 5'($urandom_range(0, 3));
            rd   = 5'($urandom_range(0, 3));
            mr   = 1'($urandom_range(0, 1));
            mbt  = ($urandom_range(0, 7) == 0);
            busy = ($urandom_range(0, 3) == 0);
            cclr = ($urandom_range(0, 31) == 0);
            eclr = !busy && ($urandom_range(0, 7) == 0);
            step("rnd", r1, r2, mr, rd, mbt, busy, cclr, eclr);
        end

        // Reset in the middle of a freeze with a parked branch
        step("rf_busy1", 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("rf_busy2", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rf_rst.ctrl_a", 32'(ctrl_a), 32'd0);
        chk("rf_rst.ctrl_b", 32'(ctrl_b), 32'd0);
        check_regs("rf_rst");
        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step("rf_after", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("rf_after2", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
